// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: forwarding selects, load-use and
// branch hazards, a timeout-guarded data-memory wait FSM, and saturating perf counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemAccessM,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_q, flush_d;

    logic lw_stall;
    logic mem_stall;
    logic wait_lt;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wr_m,
                                           input logic [4:0] rd_m,
                                           input logic       wr_w,
                                           input logic [4:0] rd_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
        end
    end

    assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
    assign wait_lt   = (wait_q < TIMEOUT);
    // In MEM_WAIT the access is already in flight, so MemAccessM no longer gates the stall.
    assign mem_stall = !dmem_ready && wait_lt && ((state_q == MEM_WAIT) || MemAccessM);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_lt) begin
                    wait_d  = wait_q + WAIT_W'(1);
                end else begin
                    state_d = RUN;
                    wait_d  = '0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (StallF && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if ((FlushD || FlushE) && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign mem_err   = err_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-level reference model checked on every
// negedge, plus hand-computed literal checks for each hazard scenario.
module tb_hazard_ctrl;

    localparam int unsigned T  = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW;
    logic [1:0]    ResultSrcE;
    logic          PCSrcE, MemAccessM, dmem_ready;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MemAccessM(MemAccessM), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory wait tracked as "in an outstanding access, N cycles waited so far".
    bit m_busy   = 1'b0;
    int m_waited = 0;
    bit m_err    = 1'b0;
    int m_sc     = 0;
    int m_fc     = 0;

    function automatic int fwd_model(input logic [4:0] rs);
        if (rst) return 0;
        if (RegWriteM && RdM != 0 && RdM == rs) return 2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            bit lw, ms, eSF, eSE, eFD, eFE, eFW;
            lw  = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
            ms  = !rst && !dmem_ready && (m_waited < T) && (m_busy || MemAccessM);
            eSF = 0; eSE = 0; eFD = 0; eFE = 0; eFW = 0;
            if (rst)              begin eFD = 1; eFE = 1; eFW = 1; end
            else if (ms)          begin eSF = 1; eSE = 1; eFW = 1; end
            else if (PCSrcE)      begin eFD = 1; eFE = 1; end
            else if (lw)          begin eSF = 1; eFE = 1; end
            check("ForwardAE", ForwardAE, fwd_model(Rs1E));
            check("ForwardBE", ForwardBE, fwd_model(Rs2E));
            check("StallF", StallF, eSF);
            check("StallD", StallD, eSF);
            check("StallE", StallE, eSE);
            check("StallM", StallM, eSE);
            check("FlushD", FlushD, eFD);
            check("FlushE", FlushE, eFE);
            check("FlushW", FlushW, eFW);
            check("mem_err", mem_err, m_err);
            check("stall_cnt", stall_cnt, m_sc);
            check("flush_cnt", flush_cnt, m_fc);
            if (rst) begin
                m_busy = 0; m_waited = 0; m_err = 0; m_sc = 0; m_fc = 0;
            end else begin
                if (eSF) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
                if (eFD || eFE) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
                if (m_busy) begin
                    if (dmem_ready) begin
                        m_busy = 0; m_waited = 0;
                    end else if (m_waited < T) begin
                        m_waited++;
                    end else begin
                        m_busy = 0; m_waited = 0; m_err = 1;
                    end
                end else if (ms) begin
                    m_busy = 1; m_waited = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
        MemAccessM = 0; dmem_ready = 1;
    endtask

    task automatic do_reset();
        tick(); clr(); rst = 1;
        tick(); rst = 0;
    endtask

    initial begin
        clr();
        rst = 1;
        tick();
        chk_en = 1;
        do_reset();
        #1;
        check("reset stall_cnt", stall_cnt, 0);
        check("reset mem_err", mem_err, 0);

        // Forwarding priority: M over W, rd==0 never forwards
        tick();
        Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        #1; check("fwdA M", ForwardAE, 2'b10); check("fwdB M", ForwardBE, 2'b10);
        tick(); RdM = 0;
        #1; check("fwdA W", ForwardAE, 2'b01);
        tick(); RdW = 0;
        #1; check("fwdA none", ForwardAE, 2'b00);
        tick(); RdM = 5; RdW = 5; RegWriteM = 0;
        #1; check("fwdA M nowrite", ForwardAE, 2'b01);

        // Load-use: one-cycle stall
        do_reset();
        ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
        #1; check("lw StallF", StallF, 1); check("lw FlushE", FlushE, 1); check("lw FlushD", FlushD, 0);
        tick(); clr();
        #1; check("lw done StallF", StallF, 0);
        check("lw stall_cnt", stall_cnt, 1); check("lw flush_cnt", flush_cnt, 1);

        // Load-use coincident with taken branch
        tick(); ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; PCSrcE = 1;
        #1; check("br FlushD", FlushD, 1); check("br FlushE", FlushE, 1); check("br StallF", StallF, 0);
        tick(); clr();
        #1; check("br flush_cnt", flush_cnt, 2); check("br stall_cnt", stall_cnt, 1);

        // Memory wait of 3 cycles, with branch and load-use ignored while frozen
        do_reset();
        MemAccessM = 1; dmem_ready = 0; PCSrcE = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
        for (int i = 0; i < 3; i++) begin
            #1; check("mw StallM", StallM, 1); check("mw FlushW", FlushW, 1); check("mw FlushE", FlushE, 0);
            tick();
        end
        dmem_ready = 1; PCSrcE = 0; ResultSrcE = 0;
        #1; check("mw ready StallF", StallF, 0);
        tick(); MemAccessM = 0; dmem_ready = 0;
        #1; check("mw back RUN", StallF, 0);
        check("mw stall_cnt", stall_cnt, 3); check("mw flush_cnt", flush_cnt, 0);

        // Timeout: T stall cycles, then abandon and raise mem_err
        do_reset();
        MemAccessM = 1; dmem_ready = 0;
        for (int i = 0; i < int'(T); i++) begin
            #1; check("to StallF", StallF, 1);
            tick();
        end
        #1; check("to abandon StallF", StallF, 0); check("to err before", mem_err, 0);
        tick(); MemAccessM = 0;
        #1; check("to mem_err", mem_err, 1); check("to stall_cnt", stall_cnt, T);
        tick(); tick();
        #1; check("to mem_err sticky", mem_err, 1);

        // Saturation under 20 load-use cycles, then reset from MEM_WAIT
        ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
        repeat (20) tick();
        clr();
        #1; check("sat stall_cnt", stall_cnt, CMAX); check("sat flush_cnt", flush_cnt, CMAX);
        check("sat mem_err", mem_err, 1);
        tick(); MemAccessM = 1; dmem_ready = 0;
        tick(); tick();
        #1; check("sat hold", stall_cnt, CMAX);
        rst = 1;
        #1; check("rst StallF", StallF, 0); check("rst FlushW", FlushW, 1); check("rst FlushD", FlushD, 1);
        tick(); rst = 0; MemAccessM = 0;
        #1; check("post rst StallF", StallF, 0); check("post rst stall_cnt", stall_cnt, 0);
        check("post rst flush_cnt", flush_cnt, 0); check("post rst mem_err", mem_err, 0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
